// File: rtl/rr_burst_scheduler_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rr_burst_scheduler_if: requester/resource bundle for rr_burst_scheduler   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
interface rr_burst_scheduler_if #(
   parameter int NUM_PORTS = 4,
   parameter int WEIGHT_W  = 4
);
   localparam int IDW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [NUM_PORTS-1:0]          req_i;
   logic [NUM_PORTS-1:0]          last_i;
   logic [NUM_PORTS*WEIGHT_W-1:0] weight_i;
   logic                          res_ready_i;
   logic [NUM_PORTS-1:0]          gnt_o;
   logic [IDW-1:0]                gnt_id_o;
   logic                          busy_o;

   modport slave (
      input  req_i, last_i, weight_i, res_ready_i,
      output gnt_o, gnt_id_o, busy_o
   );

   modport master (
      output req_i, last_i, weight_i, res_ready_i,
      input  gnt_o, gnt_id_o, busy_o
   );
endinterface
`default_nettype wire

// File: rtl/rr_burst_scheduler.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rr_burst_scheduler: weighted round-robin grant held across whole bursts   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module rr_burst_scheduler #(
   parameter int NUM_PORTS = 4,
   parameter int WEIGHT_W  = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   rr_burst_scheduler_if.slave  bus
);
   localparam int                  IDW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [WEIGHT_W-1:0] CREDIT_ONE = WEIGHT_W'(1);
   localparam logic [IDW-1:0]      LAST_PORT  = IDW'(NUM_PORTS - 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [IDW-1:0]         ptr_q, ptr_d;
   logic [IDW-1:0]         gnt_id_q, gnt_id_d;
   logic [NUM_PORTS-1:0]   gnt_q, gnt_d;
   logic [WEIGHT_W-1:0]    credit_q, credit_d;

   logic [WEIGHT_W-1:0]    weight_arr [NUM_PORTS];
   logic [WEIGHT_W-1:0]    sel_weight;
   logic [WEIGHT_W-1:0]    load_credit;

   logic [IDW-1:0]         rel_ptr;
   logic [IDW-1:0]         arb_base;
   logic [IDW-1:0]         arb_sel;
   logic [IDW-1:0]         arb_cand;
   logic [NUM_PORTS-1:0]   arb_onehot;
   logic                   arb_found;
   int                     arb_idx;

   logic                   beat;
   logic                   burst_end;
   logic                   abort;
   logic                   release_now;

   for (genvar k = 0; k < NUM_PORTS; k++) begin : g_weight
      assign weight_arr[k] = bus.weight_i[k*WEIGHT_W +: WEIGHT_W];
   end

   // Only the granted port's request/last matter while a grant is held.
   assign beat        = bus.req_i[gnt_id_q] & bus.res_ready_i;
   assign burst_end   = beat & bus.last_i[gnt_id_q];
   assign abort       = ~bus.req_i[gnt_id_q];
   assign release_now = abort | (burst_end & (credit_q == CREDIT_ONE));

   assign rel_ptr  = (gnt_id_q == LAST_PORT) ? '0 : gnt_id_q + 1'b1;
   assign arb_base = (state_q == S_GRANT) ? rel_ptr : ptr_q;

   // Rotating priority scan starting at arb_base; used both from IDLE and
   // on release so a new grant follows the old one with no bubble.
   always_comb begin
      arb_found  = 1'b0;
      arb_sel    = '0;
      arb_cand   = '0;
      arb_onehot = '0;
      arb_idx    = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         arb_idx = int'(arb_base) + i;
         if (arb_idx >= NUM_PORTS) begin
            arb_idx = arb_idx - NUM_PORTS;
         end
         arb_cand = IDW'(arb_idx);
         if (!arb_found && bus.req_i[arb_cand]) begin
            arb_found = 1'b1;
            arb_sel   = arb_cand;
         end
      end
      if (arb_found) begin
         arb_onehot[arb_sel] = 1'b1;
      end
   end

   assign sel_weight  = weight_arr[arb_sel];
   assign load_credit = (sel_weight == '0) ? CREDIT_ONE : sel_weight;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      credit_d = credit_q;
      case (state_q)
         S_IDLE: begin
            if (arb_found) begin
               state_d  = S_GRANT;
               gnt_d    = arb_onehot;
               gnt_id_d = arb_sel;
               credit_d = load_credit;
            end
         end
         S_GRANT: begin
            if (release_now) begin
               ptr_d = rel_ptr;
               if (arb_found) begin
                  gnt_d    = arb_onehot;
                  gnt_id_d = arb_sel;
                  credit_d = load_credit;
               end else begin
                  state_d  = S_IDLE;
                  gnt_d    = '0;
                  gnt_id_d = '0;
                  credit_d = '0;
               end
            end else if (burst_end) begin
               credit_d = credit_q - 1'b1;
            end
         end
         default: begin
            state_d  = S_IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            credit_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         credit_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         credit_q <= credit_d;
      end
   end

   assign bus.gnt_o    = gnt_q;
   assign bus.gnt_id_o = gnt_id_q;
   assign bus.busy_o   = |gnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_burst_scheduler.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_rr_burst_scheduler: directed self-checking bench for rr_burst_scheduler|
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_rr_burst_scheduler;
   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   rr_burst_scheduler_if #(.NUM_PORTS(4), .WEIGHT_W(4)) bus ();

   rr_burst_scheduler #(.NUM_PORTS(4), .WEIGHT_W(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] exp_g, input logic [1:0] exp_id);
      checks++;
      assert (bus.gnt_o === exp_g) else begin
         errors++;
         $error("FAIL %s gnt_o: observed %b expected %b", tag, bus.gnt_o, exp_g);
      end
      checks++;
      assert (bus.gnt_id_o === exp_id) else begin
         errors++;
         $error("FAIL %s gnt_id_o: observed %0d expected %0d", tag, bus.gnt_id_o, exp_id);
      end
      checks++;
      assert (bus.busy_o === (exp_g != 4'b0000)) else begin
         errors++;
         $error("FAIL %s busy_o: observed %b expected %b", tag, bus.busy_o, (exp_g != 4'b0000));
      end
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      reset_n         = 1'b0;
      bus.req_i       = 4'b0000;
      bus.last_i      = 4'b0000;
      bus.weight_i    = 16'h1111;
      bus.res_ready_i = 1'b0;

      tick();
      tick();
      chk("reset", 4'b0000, 2'd0);
      reset_n = 1'b1;

      // Single port, 3-beat burst, weight 1
      bus.req_i       = 4'b0001;
      bus.res_ready_i = 1'b1;
      tick(); chk("single_grant", 4'b0001, 2'd0);
      tick(); chk("single_beat1", 4'b0001, 2'd0);
      tick(); chk("single_beat2", 4'b0001, 2'd0);
      bus.last_i = 4'b0001;
      // req is still high on the last beat, so port 0 is the only candidate
      tick(); chk("single_regrant", 4'b0001, 2'd0);
      bus.req_i  = 4'b0000;
      bus.last_i = 4'b0000;
      tick(); chk("single_idle", 4'b0000, 2'd0);

      // Fair rotation; ptr is 1 after port 0 released
      bus.req_i  = 4'b1111;
      bus.last_i = 4'b1111;
      tick(); chk("rot_p1", 4'b0010, 2'd1);
      tick(); chk("rot_p2", 4'b0100, 2'd2);
      tick(); chk("rot_p3", 4'b1000, 2'd3);
      tick(); chk("rot_p0", 4'b0001, 2'd0);
      tick(); chk("rot_p1b", 4'b0010, 2'd1);

      // Weighting: port0 weight 3, port1 weight 1
      bus.req_i    = 4'b0011;
      bus.last_i   = 4'b0011;
      bus.weight_i = 16'h1113;
      tick(); chk("wt_p0_1", 4'b0001, 2'd0);
      tick(); chk("wt_p0_2", 4'b0001, 2'd0);
      tick(); chk("wt_p0_3", 4'b0001, 2'd0);
      tick(); chk("wt_p1", 4'b0010, 2'd1);
      tick(); chk("wt_p0_4", 4'b0001, 2'd0);
      tick(); chk("wt_p0_5", 4'b0001, 2'd0);
      tick(); chk("wt_p0_6", 4'b0001, 2'd0);
      tick(); chk("wt_p1b", 4'b0010, 2'd1);
      bus.weight_i = 16'h1110;
      tick(); chk("wt0_p0", 4'b0001, 2'd0);
      tick(); chk("wt0_p1", 4'b0010, 2'd1);
      tick(); chk("wt0_p0b", 4'b0001, 2'd0);
      tick(); chk("wt0_p1b", 4'b0010, 2'd1);

      // Stall and abort on port 2
      bus.weight_i    = 16'h1111;
      bus.req_i       = 4'b0100;
      bus.last_i      = 4'b0000;
      bus.res_ready_i = 1'b0;
      tick(); chk("stall_grant", 4'b0100, 2'd2);
      bus.last_i = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         tick(); chk("stall_hold", 4'b0100, 2'd2);
      end
      bus.req_i  = 4'b1001;
      bus.last_i = 4'b0000;
      tick(); chk("abort_next", 4'b1000, 2'd3);

      // Wrap and priority
      bus.req_i       = 4'b0100;
      bus.res_ready_i = 1'b1;
      tick(); chk("wrap_p2", 4'b0100, 2'd2);
      bus.req_i  = 4'b0101;
      bus.last_i = 4'b0100;
      tick(); chk("wrap_p0", 4'b0001, 2'd0);

      // Async reset mid-burst
      bus.req_i  = 4'b1000;
      bus.last_i = 4'b0000;
      tick(); chk("pre_reset", 4'b1000, 2'd3);
      #3;
      reset_n = 1'b0;
      #1;
      chk("async_reset", 4'b0000, 2'd0);
      bus.req_i = 4'b1001;
      tick();
      reset_n = 1'b1;
      tick(); chk("post_reset", 4'b0001, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
